iterative_muldiv: RTL and testbench

//  Multi-cycle integer multiply/divide unit for the execute stage. Replaces the

---
 rtl/iterative_muldiv.sv | 182 ++++++++++++++++++
 tb/tb_iterative_muldiv.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv.sv
// Multi-cycle radix-2 multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up in a final cycle.
module iterative_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             multordiv,
  input  logic             sgn,
  input  logic             kill,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [AW-1:0]    acc_q, acc_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] quo, rem;
  logic [AW-1:0]    prod;

  assign accept = (state_q == S_IDLE) && start && !kill;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; kill aborts CALC/FIX but not a committed DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: begin
        if (kill)                   state_d = S_IDLE;
        else if (cnt_q == CW'(1))   state_d = S_FIX;
      end
      S_FIX:  state_d = kill ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done come straight from flops
  always_comb begin
    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // Datapath: operand capture, one radix-2 step per CALC cycle, sign fix-up in FIX
  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    rem_neg_d = rem_neg_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    a_raw_d   = a_raw_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    a_neg = sgn & srca[WIDTH-1];
    b_neg = sgn & srcb[WIDTH-1];
    a_abs = a_neg ? (WIDTH'(0) - srca) : srca;
    b_abs = b_neg ? (WIDTH'(0) - srcb) : srcb;
    trial = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_mag_q};
    sum   = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, a_mag_q};
    quo   = acc_q[WIDTH-1:0];
    rem   = acc_q[AW-1:WIDTH];
    prod  = neg_res_q ? (AW'(0) - acc_q) : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d  = multordiv;
          neg_res_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          a_mag_d   = a_abs;
          b_mag_d   = b_abs;
          a_raw_d   = srca;
          cnt_d     = CW'(WIDTH);
          acc_d     = multordiv ? {WIDTH'(0), a_abs} : {WIDTH'(0), b_abs};
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          // No borrow in bit WIDTH means the divisor fits: keep the difference
          if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {acc_q[AW-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[AW-1:1]};
        end
      end
      S_FIX: begin
        if (!kill) begin
          if (is_div_q) begin
            if (b_mag_q == WIDTH'(0)) begin
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              lo_d = neg_res_q ? (WIDTH'(0) - quo) : quo;
              hi_d = rem_neg_q ? (WIDTH'(0) - rem) : rem;
            end
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      rem_neg_q <= 1'b0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      a_raw_q   <= '0;
      acc_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      rem_neg_q <= rem_neg_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      a_raw_q   <= a_raw_d;
      acc_q     <= acc_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Scoreboard bench for iterative_muldiv: random and corner operations against a
// plain-arithmetic reference, plus kill, ignored-start and async-reset scenarios.
module tb_iterative_muldiv;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start, multordiv, sgn, kill;
  logic [W-1:0] srca, srcb;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  iterative_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .multordiv(multordiv), .sgn(sgn),
    .kill(kill), .srca(srca), .srcb(srcb), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  res_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  int           busy_run = 0;
  logic         done_prev = 1'b0;

  // Reference: full-width integer arithmetic, language division semantics
  function automatic res_t model(input logic md, input logic sg, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t r;
    logic signed [2*W-1:0] sa, sb, sr;
    logic [2*W-1:0] ua, ub, ur;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    if (!md) begin
      if (sg) begin sr = sa * sb; {r.hi, r.lo} = sr; end
      else    begin ur = ua * ub; {r.hi, r.lo} = ur; end
    end else if (b == '0) begin
      r.hi = a;
      r.lo = '1;
    end else if (sg) begin
      sr = sa / sb; r.lo = W'(sr);
      sr = sa % sb; r.hi = W'(sr);
    end else begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred, required absent", name);
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      busy_run  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (done_prev) fail("done_multi_cycle");
        if (exp_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
          check("busy_cycles", W'(busy_run), W'(W + 1));
          last_hi = e.hi;
          last_lo = e.lo;
        end
        busy_run = 0;
      end else if (!busy) begin
        busy_run = 0;
      end
      done_prev = done;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 200) begin @(negedge clk); t++; end
    if (busy || done) fail("idle_timeout");
  endtask

  task automatic issue(input logic md, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit expect_result);
    wait_idle();
    multordiv = md; sgn = sg; srca = a; srcb = b; start = 1'b1;
    if (expect_result) exp_q.push_back(model(md, sg, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 200) begin @(negedge clk); t++; end
    if (!done) fail("done_timeout");
  endtask

  task automatic run_op(input logic md, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    issue(md, sg, a, b, 1'b1);
    wait_done();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return W'(1);
      2: return '1;
      3: return W'(32'h8000_0000);
      4: return W'(32'h7FFF_FFFF);
      5: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; kill = 1'b0; multordiv = 1'b0; sgn = 1'b0;
    srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 1'b0, 32'd100, 32'd7);
    run_op(1'b1, 1'b0, 32'd100, 32'd0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000);
    run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);

    // Kill at CALC cycle 10: busy drops next cycle, results keep prior values
    issue(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", W'(busy), '0);
    check("kill_hi", hi, last_hi);
    check("kill_lo", lo, last_lo);
    repeat (40) @(negedge clk);
    check("kill_hi_later", hi, last_hi);

    // Kill together with start in IDLE: nothing starts
    multordiv = 1'b0; sgn = 1'b0; srca = 32'd3; srcb = 32'd4;
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("kill_start_busy", W'(busy), '0);
    repeat (40) @(negedge clk);

    // Start held while busy: one result only
    issue(1'b1, 1'b0, 32'd1000, 32'd33, 1'b1);
    srca = 32'd55; srcb = 32'd66; start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Start during DONE is ignored; kill during DONE leaves the result intact
    issue(1'b0, 1'b0, 32'd9, 32'd11, 1'b1);
    wait_done();
    start = 1'b1; srca = 32'd2; srcb = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_busy", W'(busy), '0);
    issue(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_done();
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_in_done_hi", hi, last_hi);
    check("kill_in_done_lo", lo, last_lo);

    // Asynchronous reset mid-CALC
    issue(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", W'(busy), '0);
    check("rst_mid_done", W'(done), '0);
    check("rst_mid_hi", hi, '0);
    check("rst_mid_lo", lo, '0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
    end

    repeat (5) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
